flux_tag_arbiter: RTL and testbench
===================================

// Module: flux_tag_arbiter
// PURPOSE
//  Upstream feeder for the multi-flux tagged FIFO. Merges FLUX independent valid/ready
//  source streams into the FIFO's single tagged write port (wr + datain).
//  Writes the flux index into the datain MSBs and never issues a write to a flux whose
//  FIFO partition is full.
//  Arbitration is fixed-priority by default (highest index wins); round-robin is optional.
// PARAMETERS
//  WIDTH  8  FIFO word width, tag included
//  FLUX   2  number of fluxes/sources, >=2
//  (derived) TAG_WIDTH=$clog2(FLUX); PAY_WIDTH=WIDTH-TAG_WIDTH
// PORTS
//  ck        in   1               clock; single clock domain
//  rst       in   1               reset; synchronous, active-high
//  in_valid  in   FLUX            per-source valid
//  in_data   in   FLUX*PAY_WIDTH  source i payload at [i*PAY_WIDTH +: PAY_WIDTH]
//  in_ready  out  FLUX            per-source accept; combinational, one-hot or zero
//  full      in   FLUX            per-flux full from downstream FIFO
//  wr        out  1               registered write strobe to FIFO
//  datain    out  WIDTH           registered {tag, payload} to FIFO
// BEHAVIOUR
//  - Reset: wr=0, datain=0, rr_last=FLUX-1. in_ready=0 while rst=1.
//    A reset mid-transfer drops the registered write; wr=0 on the cycle after rst is sampled.
//  - Transfer on source i: in_valid[i] & in_ready[i] at a ck edge.
//    Sources hold valid and data until accepted. in_ready may depend on in_valid.
//  - Eligibility: elig[i] = in_valid[i] & ~full[i] & ~(wr & datain[WIDTH-1 -: TAG_WIDTH]==i).
//    The last term blocks a flux with a write in flight. FIFO full lags our write by one edge.
//    Consequence: one flux alone sustains at most one write every 2 cycles.
//    Different fluxes may be written back-to-back.
//  - Grant: at most one i per cycle, chosen from elig; in_ready = grant.
//  - Output register: on grant, next wr=1 and datain = {i[TAG_WIDTH-1:0], in_data slice i}.
//    With no grant, next wr=0 and datain holds its last value.
//  - Latency: accept at cycle n -> wr/datain valid in cycle n+1 -> FIFO captures at end of n+1.
//  - full[i] only gates new grants. A write already registered is never cancelled;
//    it is safe by construction of the in-flight block.
//  - Tag width: an index beyond FLUX-1 is never produced.
//    Payload MSBs above PAY_WIDTH do not exist; no truncation.
// CONFIGURATION
//  FLUX_ARB_RR_EN defined: round-robin arbitration.
//   - The search starts at rr_last+1 mod FLUX; the first elig index wins.
//   - rr_last <= granted index on each grant and is unchanged otherwise.
//   - rr_last wraps FLUX-1 -> 0.
//  Not defined: fixed priority, highest elig index wins.
//   - This matches the FIFO's default priority of flux FLUX-1.
//   - The rr_last register is absent.
// STRUCTURE
//  - Shared package flux_pkg: tag_width(FLUX) function, PAY_WIDTH computation,
//    tag-slice macro/function shared with the FIFO.
//  - One sub-module, flux_pick: combinational FLUX-wide picker with base index,
//    returning one-hot grant and binary index.
//    Fixed-priority mode ties the base to FLUX-1 and uses reversed scan order.
// TESTING (WIDTH=8, FLUX=2 unless noted)
//  1 Reset: rst=1 for 2 cycles with in_valid=2'b11 -> in_ready=0, wr=0, datain=0.
//    After release, first grant in the following cycle.
//  2 Single flux: in_valid=2'b10, in_data[13:7]=7'h15, full=0 -> wr pulses every other
//    cycle, datain=8'h95, in_ready[1] alternates 1/0.
//  3 Contention, fixed priority: in_valid=2'b11, full=0 -> datain tags 1,0,1,0...
//    wr=1 every cycle after the first.
//  4 Full gating: full=2'b10, in_valid=2'b11 -> tag 1 is never written; flux 0 every other cycle.
//    Clear full[1] -> tag 1 granted on the next free cycle.
//  5 RR (FLUX_ARB_RR_EN, FLUX=4, WIDTH=8): all valid, full=0 -> tag order 0,1,2,3,0,...
//    Drop in_valid[2] -> order 0,1,3,0.
//  6 Reset mid-operation: assert rst on a cycle where grant occurs -> no wr in the next cycle.
//    RR restarts at 0.

Source files
------------

// File: rtl/flux_pkg.sv
// Shared definitions for the multi-flux tagged FIFO and its feeders.
// Arbitration mode follows the FLUX_ARB_RR_EN macro (round-robin when defined).
package flux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

`ifdef FLUX_ARB_RR_EN
  localparam arb_mode_e ARB_MODE = ARB_RR;
`else
  localparam arb_mode_e ARB_MODE = ARB_FIXED;
`endif

  // Tag needs at least one bit even for a degenerate single-flux build.
  function automatic int tag_width(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  function automatic int pay_width(input int width, input int flux);
    return width - tag_width(flux);
  endfunction

endpackage

`ifndef FLUX_TAG_SLICE
`define FLUX_TAG_SLICE(word, width, tw) word[(width)-1 -: (tw)]
`endif

// File: rtl/flux_tag_arbiter_if.sv
// Source-side valid/ready streams plus the FIFO's tagged write port.
// master = arbiter view, slave = sources/FIFO view.
interface flux_tag_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int FLUX  = 2
);
  import flux_pkg::*;

  localparam int PAY_WIDTH = pay_width(WIDTH, FLUX);

  logic [FLUX-1:0]           in_valid;
  logic [FLUX*PAY_WIDTH-1:0] in_data;
  logic [FLUX-1:0]           in_ready;
  logic [FLUX-1:0]           full;
  logic                      wr;
  logic [WIDTH-1:0]          datain;

  modport master (
    input  in_valid, in_data, full,
    output in_ready, wr, datain
  );

  modport slave (
    output in_valid, in_data, full,
    input  in_ready, wr, datain
  );

endinterface

// File: rtl/flux_pick.sv
// Combinational N-wide picker: scans req_i starting after base_i (or at base_i
// downwards when REVERSE) and returns a one-hot grant plus its binary index.
module flux_pick
  import flux_pkg::*;
#(
  parameter int N       = 2,
  parameter bit REVERSE = 1'b0,
  localparam int TW     = tag_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [TW-1:0] base_i,
  output logic [N-1:0]  gnt_o,
  output logic [TW-1:0] idx_o,
  output logic          valid_o
);

  int cand;

  // NOTE: every output gets a default before the search so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      if (REVERSE) begin
        cand = int'(base_i) - k;
        if (cand < 0) cand += N;
      end else begin
        cand = int'(base_i) + 1 + k;
        if (cand >= N) cand -= N;
      end
      if (!valid_o && req_i[TW'(cand)]) begin
        valid_o            = 1'b1;
        gnt_o[TW'(cand)]   = 1'b1;
        idx_o              = TW'(cand);
      end
    end
  end

endmodule

// File: rtl/flux_tag_arbiter.sv
// Merges FLUX valid/ready sources into one registered, tagged FIFO write port.
// Fixed priority (highest index) by default; FLUX_ARB_RR_EN selects round-robin.
module flux_tag_arbiter
  import flux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FLUX  = 2
) (
  input  logic                 ck,
  input  logic                 rst,
  flux_tag_arbiter_if.master   bus
);

  localparam int TW  = tag_width(FLUX);
  localparam int PAY = pay_width(WIDTH, FLUX);

  logic [FLUX-1:0]  inflight;
  logic [FLUX-1:0]  elig;
  logic [FLUX-1:0]  gnt;
  logic [TW-1:0]    idx;
  logic [TW-1:0]    base;
  logic             any_gnt;
  logic [TW-1:0]    tag_q;
  logic [PAY-1:0]   pay;

  logic             wr_q,     wr_d;
  logic [WIDTH-1:0] datain_q, datain_d;

  assign tag_q = `FLUX_TAG_SLICE(datain_q, WIDTH, TW);

  // FIFO full lags our write by one edge, so the flux just written must sit out a cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < FLUX; i++) begin
      inflight[i] = wr_q && (tag_q == TW'(i));
    end
  end

  assign elig = bus.in_valid & ~bus.full & ~inflight & {FLUX{~rst}};

`ifdef FLUX_ARB_RR_EN
  logic [TW-1:0] rr_last_q, rr_last_d;

  always_comb begin
    rr_last_d = rr_last_q;
    if (any_gnt) rr_last_d = idx;
  end

  always_ff @(posedge ck) begin
    if (rst) rr_last_q <= TW'(FLUX - 1);
    else     rr_last_q <= rr_last_d;
  end

  assign base = rr_last_q;
`else
  assign base = TW'(FLUX - 1);
`endif

  flux_pick #(
    .N       (FLUX),
    .REVERSE (ARB_MODE == ARB_FIXED)
  ) u_pick (
    .req_i   (elig),
    .base_i  (base),
    .gnt_o   (gnt),
    .idx_o   (idx),
    .valid_o (any_gnt)
  );

  always_comb begin
    pay = '0;
    for (int i = 0; i < FLUX; i++) begin
      if (gnt[i]) pay = pay | bus.in_data[i*PAY +: PAY];
    end
  end

  always_comb begin
    wr_d     = any_gnt;
    datain_d = datain_q;
    if (any_gnt) datain_d = {idx, pay};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_q     <= 1'b0;
      datain_q <= '0;
    end else begin
      wr_q     <= wr_d;
      datain_q <= datain_d;
    end
  end

  assign bus.in_ready = gnt;
  assign bus.wr       = wr_q;
  assign bus.datain   = datain_q;

endmodule

// File: tb/tb_flux_tag_arbiter.sv
// Self-checking bench for flux_tag_arbiter: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed tag sequences.
module tb_flux_tag_arbiter;
  import flux_pkg::*;

`ifdef FLUX_ARB_RR_EN
  localparam int FLUX = 4;
`else
  localparam int FLUX = 2;
`endif
  localparam int WIDTH = 8;
  localparam int TW    = tag_width(FLUX);
  localparam int PAY   = WIDTH - TW;

  logic ck  = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  flux_tag_arbiter_if #(.WIDTH(WIDTH), .FLUX(FLUX)) bus ();

  flux_tag_arbiter #(.WIDTH(WIDTH), .FLUX(FLUX)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic             m_wr   = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  int               m_last = FLUX - 1;
  int               m_w;

  function automatic int model_winner();
    int cand[$];
    int tag;
    if (rst) return -1;
    tag = int'(m_data >> PAY);
    for (int i = 0; i < FLUX; i++)
      if (bus.in_valid[i] && !bus.full[i] && !(m_wr && tag == i)) cand.push_back(i);
    if (cand.size() == 0) return -1;
`ifdef FLUX_ARB_RR_EN
    for (int k = 1; k <= FLUX; k++)
      foreach (cand[j]) if (cand[j] == (m_last + k) % FLUX) return cand[j];
    return -1;
`else
    return cand[cand.size()-1];
`endif
  endfunction

  always @(posedge ck) begin
    if (rst) begin
      m_wr   = 1'b0;
      m_data = '0;
      m_last = FLUX - 1;
    end else begin
      m_w  = model_winner();
      m_wr = (m_w >= 0);
      if (m_w >= 0) begin
        m_data = WIDTH'(m_w << PAY) | WIDTH'(bus.in_data[m_w*PAY +: PAY]);
        m_last = m_w;
      end
    end
  end

  always @(negedge ck) begin
    int w;
    logic [FLUX-1:0] er;
    if (chk_en) begin
      w  = model_winner();
      er = (w >= 0) ? (FLUX'(1) << w) : '0;
      check("model_in_ready", 32'(bus.in_ready), 32'(er));
      check("model_wr",       32'(bus.wr),       32'(m_wr));
      check("model_datain",   32'(bus.datain),   32'(m_data));
    end
  end

  // ---------------- directed helpers ----------------
  logic [31:0] log_wr;
  logic [31:0] log_rdy;
  logic [31:0] log_rdy0;
  int          log_tags[$];

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic observe(input int n);
    log_wr  = '0;
    log_rdy = '0;
    log_tags.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge ck);
      if (k == 0) log_rdy0 = 32'(bus.in_ready);
      log_wr[k]  = bus.wr;
      log_rdy[k] = |bus.in_ready;
      if (bus.wr) log_tags.push_back(int'(bus.datain >> PAY));
      tick();
    end
  endtask

  task automatic check_tags(input string name, input int exp[$]);
    check({name, "_count"}, 32'(log_tags.size()), 32'(exp.size()));
    foreach (exp[i])
      if (i < log_tags.size()) check(name, 32'(log_tags[i]), 32'(exp[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    bus.full     = '0;
    bus.in_valid = '1;
`ifdef FLUX_ARB_RR_EN
    for (int i = 0; i < FLUX; i++) bus.in_data[i*PAY +: PAY] = PAY'(16 + i);
`else
    bus.in_data = {7'h15, 7'h2A};
`endif
    rst = 1'b1;

    // Reset held two cycles with all sources valid
    tick();
    chk_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge ck);
      check("rst_in_ready", 32'(bus.in_ready), 32'h0);
      check("rst_wr",       32'(bus.wr),       32'h0);
      check("rst_datain",   32'(bus.datain),   32'h0);
      tick();
    end
    rst = 1'b0;

`ifndef FLUX_ARB_RR_EN
    // Contention under fixed priority: flux 1 first, then alternating
    observe(7);
    check("t1_first_ready", log_rdy0, 32'h2);
    check("t3_wr_pattern", log_wr, 32'b1111110);
    check_tags("t3_tags", '{1, 0, 1, 0, 1, 0});

    // Single flux: one write every other cycle
    bus.in_valid = '0;
    tick(); tick();
    bus.in_valid = 2'b10;
    observe(6);
    check("t2_wr_pattern",  log_wr,  32'b101010);
    check("t2_rdy_pattern", log_rdy, 32'b010101);
    check_tags("t2_tags", '{1, 1, 1});
    check("t2_datain", 32'(bus.datain), 32'h95);

    // Full gating on flux 1
    bus.in_valid = '0;
    bus.full     = 2'b10;
    tick(); tick();
    bus.in_valid = 2'b11;
    observe(6);
    check("t4_wr_pattern", log_wr, 32'b101010);
    check_tags("t4_tags", '{0, 0, 0});
    check("t4_datain", 32'(bus.datain), 32'h2A);
    bus.full = 2'b00;
    found = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      @(negedge ck);
      if (bus.wr) begin
        found = 1'b1;
        check("t4_release_tag", 32'(bus.datain >> PAY), 32'h1);
      end
    end
    if (!found) check("t4_release_timeout", 32'h0, 32'h1);
    tick();
`else
    // Round-robin with all sources valid
    observe(9);
    check("t1_first_ready", log_rdy0, 32'h1);
    check("t5_wr_pattern", log_wr, 32'b111111110);
    check_tags("t5_tags", '{0, 1, 2, 3, 0, 1, 2, 3});

    // Round-robin with source 2 idle
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    bus.in_valid = 4'b1011;
    observe(7);
    check("t5b_wr_pattern", log_wr, 32'b1111110);
    check_tags("t5b_tags", '{0, 1, 3, 0, 1, 3});
    bus.in_valid = '1;
    tick();
`endif

    // Reset asserted on a cycle that would otherwise grant
    rst = 1'b1;
    @(negedge ck);
    check("t6_ready_in_rst", 32'(bus.in_ready), 32'h0);
    tick();
    @(negedge ck);
    check("t6_wr_after_rst",     32'(bus.wr),     32'h0);
    check("t6_datain_after_rst", 32'(bus.datain), 32'h0);
    tick();
    rst = 1'b0;
    observe(3);
    check("t6_wr_pattern", log_wr, 32'b110);
`ifdef FLUX_ARB_RR_EN
    check_tags("t6_tags", '{0, 1});
`else
    check_tags("t6_tags", '{1, 0});
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
